// File: rtl/cnn_div_pkg.sv
// Shared constants and state type for the CNN 23s / 9s sequential divider.
package cnn_div_pkg;

  localparam int unsigned DIVIDEND_W = 23;
  localparam int unsigned DIVISOR_W  = 9;
  localparam int unsigned QUOT_W     = 14;

  localparam int QUOT_MAX = 8191;
  localparam int QUOT_MIN = -8192;

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

endpackage

// File: rtl/cnn_sdiv_sat_14s.sv
// Applies signs to the magnitude quotient/remainder and clamps the quotient to
// the signed QUOT_W range; also resolves the divide-by-zero result.
module cnn_sdiv_sat_14s #(
  parameter int unsigned DIVIDEND_W = 23,
  parameter int unsigned DIVISOR_W  = 9,
  parameter int unsigned QUOT_W     = 14
) (
  input  logic [DIVIDEND_W-1:0] q_mag,
  input  logic [DIVISOR_W-1:0]  r_mag,
  input  logic                  q_neg,
  input  logic                  r_neg,
  input  logic                  div_zero,
  output logic [QUOT_W-1:0]     q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  ovf
);

  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((2 ** (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(2 ** (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W - 1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W - 1){1'b0}}};

  always_comb begin
    q   = q_mag[QUOT_W-1:0];
    r   = r_mag;
    ovf = 1'b0;
    if (div_zero) begin
      // r_neg carries the dividend sign: saturate toward it
      q = r_neg ? Q_MIN : Q_MAX;
      r = '0;
    end else begin
      if (q_neg) begin
        if (q_mag > NEG_LIM) begin
          q   = Q_MIN;
          ovf = 1'b1;
        end else begin
          q = -q_mag[QUOT_W-1:0];
        end
      end else if (q_mag > POS_LIM) begin
        q   = Q_MAX;
        ovf = 1'b1;
      end
      if (r_neg) begin
        r = -r_mag;
      end
    end
  end

endmodule

// File: rtl/cnn_sdiv_23s_9s_seq.sv
// Sequential restoring signed divider, one quotient bit per cycle, with an
// ap_ctrl_hs start/ready/idle/done handshake and a saturated 14-bit quotient.
module cnn_sdiv_23s_9s_seq #(
  parameter int unsigned DIVIDEND_W = 23,
  parameter int unsigned DIVISOR_W  = 9,
  parameter int unsigned QUOT_W     = 14
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dbz
);

  import cnn_div_pkg::*;

  localparam int unsigned CW = $clog2(DIVIDEND_W);

  state_t                state_q;
  logic [DIVIDEND_W-1:0] dq_q;      // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]  prem_q;
  logic [DIVISOR_W-1:0]  dmag_q;
  logic [CW-1:0]         cnt_q;
  logic                  q_neg_q, r_neg_q, dz_q;
  logic                  done_q, idle_q;
  logic [QUOT_W-1:0]     quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic                  ovf_q, dbz_q;

  logic [DIVIDEND_W-1:0] dvd_abs;
  logic [DIVISOR_W-1:0]  dvs_abs;
  logic [DIVISOR_W:0]    prem_shift, diff;
  logic                  fits;
  logic [QUOT_W-1:0]     sat_q;
  logic [DIVISOR_W-1:0]  sat_r;
  logic                  sat_ovf;

  assign dvd_abs = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
  assign dvs_abs = divisor[DIVISOR_W-1] ? (~divisor + 1'b1) : divisor;

  // Restoring step: a negative trial difference means the divisor did not fit
  assign prem_shift = {prem_q, dq_q[DIVIDEND_W-1]};
  assign diff       = prem_shift - {1'b0, dmag_q};
  assign fits       = ~diff[DIVISOR_W];

  cnn_sdiv_sat_14s #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (DIVISOR_W),
    .QUOT_W    (QUOT_W)
  ) u_sat (
    .q_mag   (dq_q),
    .r_mag   (prem_q),
    .q_neg   (q_neg_q),
    .r_neg   (r_neg_q),
    .div_zero(dz_q),
    .q       (sat_q),
    .r       (sat_r),
    .ovf     (sat_ovf)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= IDLE;
      dq_q    <= '0;
      prem_q  <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ap_start) begin
            dq_q    <= dvd_abs;
            dmag_q  <= dvs_abs;
            q_neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            r_neg_q <= dividend[DIVIDEND_W-1];
            dz_q    <= (divisor == '0);
            prem_q  <= '0;
            cnt_q   <= CW'(DIVIDEND_W - 1);
            idle_q  <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          dq_q   <= {dq_q[DIVIDEND_W-2:0], fits};
          prem_q <= fits ? diff[DIVISOR_W-1:0] : prem_shift[DIVISOR_W-1:0];
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q  <= sat_q;
          rem_q   <= sat_r;
          ovf_q   <= sat_ovf;
          dbz_q   <= dz_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          idle_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ap_ready  = idle_q & ap_start & ~ap_rst;
  assign ap_idle   = idle_q;
  assign ap_done   = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: doc/cnn_sdiv_23s_9s_seq.md
Name: cnn_sdiv_23s_9s_seq

Overview:
- Sequential signed integer divider. It is the inverse datapath of the CNN 14s x 9s -> 23s product multiplier.
- Takes a 23-bit signed dividend (accumulated product) and a 9-bit signed divisor. Returns a 14-bit signed saturated quotient and a 9-bit signed remainder.
- Used for average-pool and normalisation rescaling back to the 14-bit activation format.
- Uses an ap_ctrl_hs-style start/done handshake and a one-bit-per-cycle restoring algorithm, so no DSP is consumed.

Parameters:
- DIVIDEND_W, 23, dividend width (signed)
- DIVISOR_W, 9, divisor width (signed)
- QUOT_W, 14, quotient output width (signed, saturating)

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst  in  1  synchronous, active-high reset
- ap_start  in  1  request; sampled only in IDLE
- ap_ready  out  1  one-cycle pulse: operands accepted
- ap_idle  out  1  high while in IDLE
- ap_done  out  1  one-cycle pulse: results valid
- dividend  in  DIVIDEND_W  signed dividend; captured on acceptance
- divisor  in  DIVISOR_W  signed divisor; captured on acceptance
- quotient  out  QUOT_W  signed quotient, truncated toward zero, saturated
- remainder  out  DIVISOR_W  signed remainder; sign follows the dividend
- ovf  out  1  quotient was clamped
- dbz  out  1  divisor was zero

Behaviour:
- Reset (ap_rst=1 at a rising edge):
  - state -> IDLE.
  - quotient, remainder, ovf, dbz, ap_done and ap_ready all 0; ap_idle 1.
  - Applies from any state. A reset mid-operation aborts the division with no ap_done.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - ap_idle=1.
  - If ap_start=1: ap_ready=1 combinationally in the same cycle, and at the edge the block captures |dividend|, |divisor| (unsigned, DIVIDEND_W and DIVISOR_W bits), both operand signs and the zero-divisor flag.
  - Then: partial remainder <- 0, bit counter <- DIVIDEND_W-1, go to CALC.
- CALC, exactly DIVIDEND_W cycles, one restoring step per cycle:
  - Shift the next dividend MSB into the partial remainder (DIVISOR_W+1 bits).
  - If the partial remainder >= |divisor|: subtract and shift a 1 into the magnitude quotient (DIVIDEND_W bits); otherwise shift a 0.
  - The counter decrements; when it reaches 0 the block goes to FIX.
- FIX, 1 cycle:
  - Quotient sign = sign(dividend) XOR sign(divisor). Remainder sign = sign(dividend).
  - Clamp the quotient to [-2^(QUOT_W-1), 2^(QUOT_W-1)-1], i.e. [-8192, 8191]. ovf=1 if the clamp is active.
  - The remainder is the true remainder. |r| < |d| <= 256, so it always fits in 9 bits.
  - Divisor zero: quotient = +8191 if dividend >= 0, else -8192; remainder = 0; dbz=1; ovf=0.
  - Outputs are registered at the end of FIX.
- DONE, 1 cycle:
  - ap_done=1; ap_idle=0.
  - ap_start is ignored in DONE and not accepted. The block returns to IDLE.
- Latency: acceptance in cycle k gives ap_done in cycle k+DIVIDEND_W+2 (cycle k+25 with defaults). Initiation interval is DIVIDEND_W+3 (26).
- quotient, remainder, ovf and dbz hold their value from DONE until the next FIX completes.
- ap_start while in CALC, FIX or DONE: no effect, ap_ready=0.
- Operand inputs may change freely after acceptance.
- Corner case: dividend = -2^22 has magnitude 2^22, which fits in the 23-bit unsigned magnitude register. No special case is needed.

Decomposition:
- Package cnn_div_pkg:
  - width constants DIVIDEND_W, DIVISOR_W, QUOT_W
  - QUOT_MAX = 8191, QUOT_MIN = -8192
  - state enum {IDLE, CALC, FIX, DONE}
  - counter width = clog2(DIVIDEND_W)
- One sub-module: cnn_sdiv_sat_14s. It is combinational and applies the sign to the magnitude quotient and remainder, clamps the quotient, and generates ovf. It is instantiated in the FIX path.

Test Plan:
- 1000 / 7, start held 1 cycle -> ap_ready in the same cycle; ap_done exactly 25 cycles later; q=142, r=6, ovf=0, dbz=0.
- Sign coverage: -1000/7 -> q=-142, r=-6; 1000/-7 -> q=-142, r=6; -1000/-7 -> q=142, r=-6.
- Saturation: 100000/7 -> q=8191, r=5, ovf=1; -4194304/-1 -> q=8191, r=0, ovf=1; -4194304/1 -> q=-8192, ovf=1.
- Divide by zero: 500/0 -> q=8191, r=0, dbz=1, ovf=0; -500/0 -> q=-8192, dbz=1.
- Handshake: ap_start held high continuously -> accepted only in IDLE, ap_done every 26 cycles. Results hold between pulses. Changing operands mid-CALC does not alter the result.
- Reset mid-op: assert ap_rst in CALC cycle 10 -> next cycle IDLE, ap_idle=1, all outputs 0, no ap_done. A new 1000/7 then completes normally.
